feedback_rx: RTL and testbench

FEEDBACK_RX -- requirements
Module: feedback_rx

---
 rtl/feedback_rx.sv | 162 ++++++++++++++++
 tb/tb_feedback_rx.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feedback_rx.sv
// Feedback packet receiver: filters incoming packets by cluster, destination and
// source, then writes the sender's battery status and value into two memory tables.
module feedback_rx #(
    parameter int unsigned           WORD_WIDTH = 16,
    parameter logic [WORD_WIDTH-1:0] BATT_BASE  = 16'h0148,
    parameter logic [WORD_WIDTH-1:0] VAL_BASE   = 16'h01C8,
    parameter logic [WORD_WIDTH-1:0] BCAST_ID   = 16'hFFFF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [5*WORD_WIDTH-1:0]   pkt_in,
    input  logic                      pkt_valid,
    output logic                      pkt_ready,
    input  logic [WORD_WIDTH-1:0]     MY_NODE_ID,
    input  logic [WORD_WIDTH-1:0]     MY_CLUSTER_ID,
    output logic [WORD_WIDTH-1:0]     address,
    output logic [WORD_WIDTH-1:0]     data_out,
    output logic                      wr_en,
    output logic                      done,
    output logic                      dropped,
    output logic [7:0]                rx_count,
    output logic [7:0]                drop_count
);

    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] src;
        logic [WORD_WIDTH-1:0] batt;
        logic [WORD_WIDTH-1:0] value;
        logic [WORD_WIDTH-1:0] cluster;
        logic [WORD_WIDTH-1:0] dest;
    } pkt_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        WR_BATT = 3'd2,
        WR_VAL  = 3'd3,
        FIN     = 3'd4
    } state_e;

    state_e                state_q, state_d;
    pkt_t                  pkt_q, pkt_d;
    logic                  drop_q, drop_d;
    logic [CNT_W-1:0]      rx_q, rx_d;
    logic [CNT_W-1:0]      dc_q, dc_d;
    logic                  ready_q, ready_d;
    logic                  wr_en_q, wr_en_d;
    logic [WORD_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  dropped_q, dropped_d;
    logic                  accept_c;

    // State, packet and registered outputs; reset aborts any packet in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pkt_q     <= '0;
            drop_q    <= 1'b0;
            rx_q      <= '0;
            dc_q      <= '0;
            ready_q   <= 1'b1;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pkt_q     <= pkt_d;
            drop_q    <= drop_d;
            rx_q      <= rx_d;
            dc_q      <= dc_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            dropped_q <= dropped_d;
        end
    end

    // Next state, then outputs decoded from the next state so they line up with it.
    always_comb begin
        state_d   = state_q;
        pkt_d     = pkt_q;
        drop_d    = drop_q;
        rx_d      = rx_q;
        dc_d      = dc_q;
        ready_d   = 1'b0;
        wr_en_d   = 1'b0;
        addr_d    = '0;
        data_d    = '0;
        done_d    = 1'b0;
        dropped_d = 1'b0;

        accept_c = (pkt_q.cluster == MY_CLUSTER_ID) &&
                   ((pkt_q.dest == MY_NODE_ID) || (pkt_q.dest == BCAST_ID)) &&
                   (pkt_q.src != MY_NODE_ID);

        case (state_q)
            IDLE: begin
                if (pkt_valid) begin
                    pkt_d   = pkt_t'(pkt_in);
                    drop_d  = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (accept_c) begin
                    drop_d  = 1'b0;
                    state_d = WR_BATT;
                end else begin
                    drop_d  = 1'b1;
                    state_d = FIN;
                end
            end
            WR_BATT: state_d = WR_VAL;
            WR_VAL:  state_d = FIN;
            FIN: begin
                state_d = IDLE;
                if (drop_q) begin
                    if (dc_q != {CNT_W{1'b1}}) dc_d = dc_q + CNT_W'(1);
                end else begin
                    if (rx_q != {CNT_W{1'b1}}) rx_d = rx_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            IDLE:    ready_d = 1'b1;
            WR_BATT: begin
                wr_en_d = 1'b1;
                addr_d  = WORD_WIDTH'(BATT_BASE + pkt_d.src);
                data_d  = pkt_d.batt;
            end
            WR_VAL: begin
                wr_en_d = 1'b1;
                addr_d  = WORD_WIDTH'(VAL_BASE + pkt_d.src);
                data_d  = pkt_d.value;
            end
            FIN: begin
                done_d    = 1'b1;
                dropped_d = drop_d;
            end
            default: ;
        endcase
    end

    assign pkt_ready  = ready_q;
    assign wr_en      = wr_en_q;
    assign address    = addr_q;
    assign data_out   = data_q;
    assign done       = done_q;
    assign dropped    = dropped_q;
    assign rx_count   = rx_q;
    assign drop_count = dc_q;

endmodule

// File: tb/tb_feedback_rx.sv
// Randomized self-checking bench for feedback_rx with a per-packet reference model
// giving the expected write/done pattern for each cycle after capture.
module tb_feedback_rx;

    localparam logic [15:0] BATT_BASE = 16'h0148;
    localparam logic [15:0] VAL_BASE  = 16'h01C8;
    localparam logic [15:0] BCAST     = 16'hFFFF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [79:0] pkt_in = '0;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [15:0] my_node = '0;
    logic [15:0] my_cl = '0;
    logic [15:0] address, data_out;
    logic        wr_en, done, dropped;
    logic [7:0]  rx_count, drop_count;

    int n_tests = 0;
    int n_fail  = 0;
    int m_rx    = 0;
    int m_dc    = 0;

    logic        obs_wr [1:6], obs_done [1:6], obs_drop [1:6], obs_rdy [1:6];
    logic [15:0] obs_addr [1:6], obs_data [1:6];
    logic [7:0]  obs_rx, obs_dc;
    logic        exp_wr [1:6], exp_done [1:6], exp_drop [1:6], exp_rdy [1:6];
    logic [15:0] exp_addr [1:6], exp_data [1:6];

    feedback_rx dut (
        .clock         (clock),
        .reset         (reset),
        .pkt_in        (pkt_in),
        .pkt_valid     (pkt_valid),
        .pkt_ready     (pkt_ready),
        .MY_NODE_ID    (my_node),
        .MY_CLUSTER_ID (my_cl),
        .address       (address),
        .data_out      (data_out),
        .wr_en         (wr_en),
        .done          (done),
        .dropped       (dropped),
        .rx_count      (rx_count),
        .drop_count    (drop_count)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [79:0] mk(input logic [15:0] s, b, v, c, d);
        return {s, b, v, c, d};
    endfunction

    // Reference: accepted packets write in cycles 2 and 3 and finish in 4; others finish in 2.
    task automatic model_pkt(input logic [79:0] p, input logic [15:0] node, input logic [15:0] cl);
        logic [15:0] s, b, v, c, d;
        logic acc;
        int   dcyc;
        {s, b, v, c, d} = p;
        acc  = (c == cl) && (d == node || d == BCAST) && (s != node);
        dcyc = acc ? 4 : 2;
        for (int k = 1; k <= 6; k++) begin
            exp_wr[k]   = 1'b0;
            exp_addr[k] = '0;
            exp_data[k] = '0;
            exp_done[k] = (k == dcyc);
            exp_drop[k] = (k == dcyc) && !acc;
            exp_rdy[k]  = (k > dcyc);
        end
        if (acc) begin
            exp_wr[2] = 1'b1; exp_addr[2] = BATT_BASE + s; exp_data[2] = b;
            exp_wr[3] = 1'b1; exp_addr[3] = VAL_BASE + s;  exp_data[3] = v;
            if (m_rx < 255) m_rx++;
        end else if (m_dc < 255) begin
            m_dc++;
        end
    endtask

    // Drives one packet and records six cycles of outputs; scrambles inputs after use.
    task automatic run_pkt(input logic [79:0] p, input logic [15:0] node, input logic [15:0] cl);
        int guard = 0;
        my_node = node;
        my_cl   = cl;
        pkt_in  = p;
        while (pkt_ready !== 1'b1 && guard < 20) begin
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL ready_timeout: got pkt_ready=%b want 1", pkt_ready);
        end
        pkt_valid = 1'b1;
        @(posedge clock); #1;
        pkt_valid = 1'b0;
        pkt_in = 80'({$urandom, $urandom, $urandom});
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) begin
                @(posedge clock); #1;
            end
            if (k == 2) begin
                my_node = 16'($urandom);
                my_cl   = 16'($urandom);
            end
            obs_wr[k] = wr_en; obs_addr[k] = address; obs_data[k] = data_out;
            obs_done[k] = done; obs_drop[k] = dropped; obs_rdy[k] = pkt_ready;
        end
        obs_rx = rx_count;
        obs_dc = drop_count;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_tests++;
        if ({pkt_ready, wr_en, address, data_out, done, dropped, rx_count, drop_count} !==
            {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 8'h0, 8'h0}) begin
            n_fail++;
            $display("FAIL reset_async: got rdy=%b wr=%b addr=%h data=%h done=%b drop=%b rx=%h dc=%h want 1 0 0 0 0 0 0 0",
                     pkt_ready, wr_en, address, data_out, done, dropped, rx_count, drop_count);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        n_tests++;
        if ({pkt_ready, wr_en, done, rx_count, drop_count} !== {1'b1, 1'b0, 1'b0, 8'h0, 8'h0}) begin
            n_fail++;
            $display("FAIL reset_idle: got rdy=%b wr=%b done=%b rx=%h dc=%h want 1 0 0 0 0",
                     pkt_ready, wr_en, done, rx_count, drop_count);
        end
        m_rx = 0;
        m_dc = 0;
    endtask

    task automatic test_directed();
        logic [79:0] vec [5];
        vec[0] = mk(16'h0005, 16'h0064, 16'h0020, 16'h0001, 16'h0003);
        vec[1] = mk(16'h0005, 16'h0064, 16'h0020, 16'h0001, 16'hFFFF);
        vec[2] = mk(16'h0005, 16'h0064, 16'h0020, 16'h0002, 16'h0003);
        vec[3] = mk(16'h0003, 16'h0064, 16'h0020, 16'h0001, 16'h0003);
        vec[4] = mk(16'hFF00, 16'h0064, 16'h0020, 16'h0001, 16'h0003);
        for (int i = 0; i < 5; i++) begin
            model_pkt(vec[i], 16'd3, 16'd1);
            run_pkt(vec[i], 16'd3, 16'd1);
            for (int k = 1; k <= 6; k++) begin
                n_tests++;
                if ({obs_wr[k], obs_addr[k], obs_data[k], obs_done[k], obs_drop[k], obs_rdy[k]} !==
                    {exp_wr[k], exp_addr[k], exp_data[k], exp_done[k], exp_drop[k], exp_rdy[k]}) begin
                    n_fail++;
                    $display("FAIL directed%0d cycle%0d: got wr=%b addr=%h data=%h done=%b drop=%b rdy=%b want wr=%b addr=%h data=%h done=%b drop=%b rdy=%b",
                             i, k, obs_wr[k], obs_addr[k], obs_data[k], obs_done[k], obs_drop[k], obs_rdy[k],
                             exp_wr[k], exp_addr[k], exp_data[k], exp_done[k], exp_drop[k], exp_rdy[k]);
                end
            end
            n_tests++;
            if (obs_rx !== 8'(m_rx) || obs_dc !== 8'(m_dc)) begin
                n_fail++;
                $display("FAIL directed%0d counters: got rx=%0d dc=%0d want rx=%0d dc=%0d", i, obs_rx, obs_dc, m_rx, m_dc);
            end
            if (i == 0) begin
                n_tests++;
                if (obs_addr[2] !== 16'h014D || obs_data[2] !== 16'h0064 || obs_addr[3] !== 16'h01CD || obs_data[3] !== 16'h0020) begin
                    n_fail++;
                    $display("FAIL basic_writes: got %h/%h %h/%h want 014d/0064 01cd/0020",
                             obs_addr[2], obs_data[2], obs_addr[3], obs_data[3]);
                end
            end
            if (i == 4) begin
                n_tests++;
                if (obs_addr[2] !== 16'h0048) begin
                    n_fail++;
                    $display("FAIL addr_wrap: got %h want 0048", obs_addr[2]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] node, cl, s, d, c;
        logic [79:0] p;
        for (int i = 0; i < 40; i++) begin
            node = 16'($urandom_range(0, 15));
            cl   = 16'($urandom_range(0, 3));
            s = ($urandom_range(0, 3) == 0) ? node : 16'($urandom);
            c = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : cl;
            case ($urandom_range(0, 2))
                0:       d = node;
                1:       d = BCAST;
                default: d = 16'($urandom_range(0, 15));
            endcase
            p = mk(s, 16'($urandom), 16'($urandom), c, d);
            model_pkt(p, node, cl);
            run_pkt(p, node, cl);
            for (int k = 1; k <= 6; k++) begin
                n_tests++;
                if ({obs_wr[k], obs_addr[k], obs_data[k], obs_done[k], obs_drop[k], obs_rdy[k]} !==
                    {exp_wr[k], exp_addr[k], exp_data[k], exp_done[k], exp_drop[k], exp_rdy[k]}) begin
                    n_fail++;
                    $display("FAIL random%0d cycle%0d: got wr=%b addr=%h data=%h done=%b drop=%b rdy=%b want wr=%b addr=%h data=%h done=%b drop=%b rdy=%b",
                             i, k, obs_wr[k], obs_addr[k], obs_data[k], obs_done[k], obs_drop[k], obs_rdy[k],
                             exp_wr[k], exp_addr[k], exp_data[k], exp_done[k], exp_drop[k], exp_rdy[k]);
                end
            end
            n_tests++;
            if (obs_rx !== 8'(m_rx) || obs_dc !== 8'(m_dc)) begin
                n_fail++;
                $display("FAIL random%0d counters: got rx=%0d dc=%0d want rx=%0d dc=%0d", i, obs_rx, obs_dc, m_rx, m_dc);
            end
        end
    endtask

    task automatic test_back_to_back();
        int got_done[$], got_wr[$], want_done[$], want_wr[$];
        my_node   = 16'd3;
        my_cl     = 16'd1;
        pkt_in    = mk(16'h0007, 16'h1234, 16'h5678, 16'h0001, 16'h0003);
        pkt_valid = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clock); #1;
            if (done === 1'b1) got_done.push_back(c);
            if (wr_en === 1'b1) got_wr.push_back(c);
            if (c == 10) pkt_valid = 1'b0;
        end
        // Valid seen on edges 0..9; a new capture happens on the edge ending the cycle after done.
        for (int e = 0; e <= 9; e = e + 5) begin
            want_wr.push_back(e + 2);
            want_wr.push_back(e + 3);
            want_done.push_back(e + 4);
            if (m_rx < 255) m_rx++;
        end
        n_tests++;
        if (got_done.size() != want_done.size() || got_wr.size() != want_wr.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d done %0d writes want %0d done %0d writes",
                     got_done.size(), got_wr.size(), want_done.size(), want_wr.size());
        end else begin
            for (int i = 0; i < want_done.size(); i++) begin
                n_tests++;
                if (got_done[i] != want_done[i]) begin
                    n_fail++;
                    $display("FAIL b2b_done%0d: got cycle %0d want cycle %0d", i, got_done[i], want_done[i]);
                end
            end
            for (int i = 0; i < want_wr.size(); i++) begin
                n_tests++;
                if (got_wr[i] != want_wr[i]) begin
                    n_fail++;
                    $display("FAIL b2b_wr%0d: got cycle %0d want cycle %0d", i, got_wr[i], want_wr[i]);
                end
            end
        end
        n_tests++;
        if (rx_count !== 8'(m_rx)) begin
            n_fail++;
            $display("FAIL b2b_rx: got %0d want %0d", rx_count, m_rx);
        end
    endtask

    task automatic test_reset_abort();
        logic wr_seen = 1'b0;
        logic done_seen = 1'b0;
        my_node   = 16'd3;
        my_cl     = 16'd1;
        pkt_in    = mk(16'h0005, 16'h0064, 16'h0020, 16'h0001, 16'h0003);
        pkt_valid = 1'b1;
        @(posedge clock); #1;
        pkt_valid = 1'b0;
        @(posedge clock); #1;
        n_tests++;
        if (wr_en !== 1'b1 || address !== 16'h014D) begin
            n_fail++;
            $display("FAIL abort_pre: got wr=%b addr=%h want wr=1 addr=014d", wr_en, address);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({wr_en, address, data_out, done, dropped, pkt_ready, rx_count, drop_count} !==
            {1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 8'h0, 8'h0}) begin
            n_fail++;
            $display("FAIL abort_reset: got wr=%b addr=%h data=%h done=%b drop=%b rdy=%b rx=%h dc=%h want 0 0 0 0 0 1 0 0",
                     wr_en, address, data_out, done, dropped, pkt_ready, rx_count, drop_count);
        end
        m_rx = 0;
        m_dc = 0;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            wr_seen   = wr_seen | (wr_en !== 1'b0);
            done_seen = done_seen | (done !== 1'b0);
        end
        n_tests++;
        if (wr_seen || done_seen) begin
            n_fail++;
            $display("FAIL abort_quiet: got wr_seen=%b done_seen=%b want 0 0", wr_seen, done_seen);
        end
        model_pkt(mk(16'h0009, 16'h00AA, 16'h00BB, 16'h0001, 16'h0003), 16'd3, 16'd1);
        run_pkt(mk(16'h0009, 16'h00AA, 16'h00BB, 16'h0001, 16'h0003), 16'd3, 16'd1);
        n_tests++;
        if (obs_wr[2] !== 1'b1 || obs_addr[2] !== exp_addr[2] || obs_done[4] !== 1'b1 || obs_rx !== 8'(m_rx)) begin
            n_fail++;
            $display("FAIL post_reset_pkt: got wr=%b addr=%h done=%b rx=%0d want wr=1 addr=%h done=1 rx=%0d",
                     obs_wr[2], obs_addr[2], obs_done[4], obs_rx, exp_addr[2], m_rx);
        end
    endtask

    task automatic test_saturation();
        logic [79:0] p;
        for (int i = 0; i < 260; i++) begin
            p = mk(16'($urandom_range(4, 200)), 16'($urandom), 16'($urandom), 16'h0002, 16'h0003);
            model_pkt(p, 16'd3, 16'd1);
            run_pkt(p, 16'd3, 16'd1);
        end
        n_tests++;
        if (obs_dc !== 8'hFF || obs_dc !== 8'(m_dc)) begin
            n_fail++;
            $display("FAIL drop_saturate: got %0d want %0d", obs_dc, m_dc);
        end
        for (int i = 0; i < 260; i++) begin
            p = mk(16'($urandom_range(4, 200)), 16'($urandom), 16'($urandom), 16'h0001, 16'hFFFF);
            model_pkt(p, 16'd3, 16'd1);
            run_pkt(p, 16'd3, 16'd1);
        end
        n_tests++;
        if (obs_rx !== 8'hFF || obs_rx !== 8'(m_rx) || obs_dc !== 8'(m_dc)) begin
            n_fail++;
            $display("FAIL rx_saturate: got rx=%0d dc=%0d want rx=%0d dc=%0d", obs_rx, obs_dc, m_rx, m_dc);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
